// File: rtl/decode_stage_if.sv
// Bus bundle for decode_stage: fetch handshake, register file read port,
// writeback retire, flush, and the decoded output toward execute.
// The slave modport is the decode stage's view; master is its environment.
interface decode_stage_if;
  // fetch side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  // register file read port
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  // writeback retire and redirect
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  // execute side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rd1, rd2,
           wb_valid, wb_rd, wb_data, flush, out_ready,
    output in_ready, a1, a2,
           out_valid, out_pc, out_op1, out_op2, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rd1, rd2,
           wb_valid, wb_rd, wb_data, flush, out_ready,
    input  in_ready, a1, a2,
           out_valid, out_pc, out_op1, out_op2, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a write scoreboard for read-after-write stalls.
// Register file reads are addressed combinationally from the incoming
// instruction; decoded fields and read data land in one output register.
// Optional macro DECODE_BYPASS_EN forwards wb_data into the operands so a
// dependent instruction issues in the writeback cycle instead of one later.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  logic [31:0]      instr;
  opcode_t          opc;
  logic [4:0]       rs1, rs2, rd_field;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  logic             uses_rs1, uses_rs2, writes, illegal;
  logic [XLEN-1:0]  imm;
  logic [4:0]       rd_dec;

  logic [NREGS-1:0] sb, sb_next;
  logic             wb_hit;
  logic             byp1, byp2;
  logic             busy1, busy2, stall;
  logic             accept;
  logic [XLEN-1:0]  op1, op2;

  assign instr    = bus.in_instr;
  assign opc      = opcode_t'(instr[6:0]);
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd_field = instr[11:7];

  assign bus.a1 = rs1;
  assign bus.a2 = rs2;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode classification: operand usage, write intent and immediate format.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    illegal  = 1'b0;
    imm      = '0;
    case (opc)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        writes   = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        uses_rs1 = 1'b1;
        writes   = 1'b1;
        imm      = imm_i;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_s;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        writes = 1'b1;
        imm    = imm_u;
      end
      OPC_JAL: begin
        writes = 1'b1;
        imm    = imm_j;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        imm = imm_i;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Destination is reported as 0 whenever nothing architectural is written.
  assign rd_dec = (writes && rd_field != 5'd0) ? rd_field : 5'd0;

  assign wb_hit = bus.wb_valid && (bus.wb_rd != 5'd0);

`ifdef DECODE_BYPASS_EN
  // A retiring producer is forwarded instead of counted as busy.
  assign byp1 = uses_rs1 && wb_hit && (bus.wb_rd == rs1);
  assign byp2 = uses_rs2 && wb_hit && (bus.wb_rd == rs2);
  assign op1  = byp1 ? bus.wb_data : bus.rd1;
  assign op2  = byp2 ? bus.wb_data : bus.rd2;
`else
  // Without forwarding, writeback data is not needed here.
  logic unused_wb_data;
  assign unused_wb_data = ^bus.wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign op1  = bus.rd1;
  assign op2  = bus.rd2;
`endif

  // sb[0] is held at zero, so x0 never reads as busy.
  assign busy1 = uses_rs1 && sb[rs1] && !byp1;
  assign busy2 = uses_rs2 && sb[rs2] && !byp2;
  assign stall = busy1 || busy2;

  assign bus.in_ready = rst_n && !bus.flush && !stall && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Scoreboard next state: retire clears, flush drops the squashed producer,
  // and a new producer's set is applied last so it wins a same-cycle clear.
  always_comb begin
    sb_next = sb;
    if (wb_hit)
      sb_next[bus.wb_rd] = 1'b0;
    if (bus.flush && bus.out_valid && bus.out_rd != 5'd0)
      sb_next[bus.out_rd] = 1'b0;
    if (accept && rd_dec != 5'd0)
      sb_next[rd_dec] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Scoreboard state register.
  // NOTE: the scoreboard is reset; stale busy bits would stall issue forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sb <= '0;
    else
      sb <= sb_next;
  end

  // Output pipeline register: flush beats accept, accept beats hold/drain.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.out_op1     <= '0;
      bus.out_op2     <= '0;
      bus.out_imm     <= '0;
      bus.out_rd      <= '0;
      bus.out_opcode  <= '0;
      bus.out_funct3  <= '0;
      bus.out_funct7  <= '0;
      bus.out_illegal <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_pc      <= bus.in_pc;
      bus.out_op1     <= op1;
      bus.out_op2     <= op2;
      bus.out_imm     <= imm;
      bus.out_rd      <= rd_dec;
      bus.out_opcode  <= instr[6:0];
      bus.out_funct3  <= instr[14:12];
      bus.out_funct7  <= instr[31:25];
      bus.out_illegal <= illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: reset, RAW stall/release, backpressure,
// flush, same-cycle scoreboard set/clear, and immediate/illegal decoding.
// Builds with or without DECODE_BYPASS_EN.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] regs [32];

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model feeding the read ports.
  assign bus.rd1 = (bus.a1 == 5'd0) ? 32'd0 : regs[bus.a1];
  assign bus.rd2 = (bus.a2 == 5'd0) ? 32'd0 : regs[bus.a2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[2] = 32'd7;

    rst_n         = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    issue(32'h0050_0093, 32'h100);        // addi x1,x0,5

    // Reset held with a pending instruction.
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_out_pc", bus.out_pc, 0);

    rst_n = 1'b1;
    settle();
    check("addi_in_ready", bus.in_ready, 1);
    tick();
    check("addi_valid", bus.out_valid, 1);
    check("addi_rd", bus.out_rd, 1);
    check("addi_imm", bus.out_imm, 5);
    check("addi_op1", bus.out_op1, 0);
    check("addi_pc", bus.out_pc, 32'h100);
    check("addi_opcode", bus.out_opcode, 7'h13);
    check("addi_illegal", bus.out_illegal, 0);

    // RAW hazard on x1.
    issue(32'h0020_81B3, 32'h104);        // add x3,x1,x2
    settle();
    check("raw_stall", bus.in_ready, 0);
    tick();
    check("raw_drain", bus.out_valid, 0);
    check("raw_stall2", bus.in_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'd5;
    settle();
`ifdef DECODE_BYPASS_EN
    check("raw_wb_ready", bus.in_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    regs[1] = 32'd5;
`else
    check("raw_wb_ready", bus.in_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    regs[1] = 32'd5;
    settle();
    check("raw_post_wb_ready", bus.in_ready, 1);
    tick();
`endif
    check("add_valid", bus.out_valid, 1);
    check("add_rd", bus.out_rd, 3);
    check("add_op1", bus.out_op1, 5);
    check("add_op2", bus.out_op2, 7);
    check("add_imm", bus.out_imm, 0);
    check("add_opcode", bus.out_opcode, 7'h33);
    check("add_pc", bus.out_pc, 32'h104);

    // Backpressure for three cycles.
    bus.out_ready = 1'b0;
    issue(32'hFFF0_0213, 32'h108);        // addi x4,x0,-1
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_in_ready", bus.in_ready, 0);
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_rd", bus.out_rd, 3);
      check("bp_pc", bus.out_pc, 32'h104);
      check("bp_op1", bus.out_op1, 5);
    end
    bus.out_ready = 1'b1;
    settle();
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    check("bp_next_rd", bus.out_rd, 4);
    check("bp_next_imm", bus.out_imm, 32'hFFFF_FFFF);
    check("bp_next_pc", bus.out_pc, 32'h108);

    // Flush while addi x1 sits in the output register.
    issue(32'h0050_0093, 32'h10C);        // addi x1,x0,5
    tick();
    check("fl_hold_rd", bus.out_rd, 1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b0;
    issue(32'h0000_82B3, 32'h110);        // add x5,x1,x0
    settle();
    check("fl_in_ready", bus.in_ready, 0);
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    check("fl_valid", bus.out_valid, 0);
    settle();
    check("fl_sb_cleared", bus.in_ready, 1);
    tick();
    check("fl_next_rd", bus.out_rd, 5);
    check("fl_next_op1", bus.out_op1, 5);
    check("fl_next_pc", bus.out_pc, 32'h110);

    // Same-cycle retire and new producer of x5: set must win.
    issue(32'h0090_0293, 32'h114);        // addi x5,x0,9
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'h55;
    settle();
    check("same_in_ready", bus.in_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    regs[5] = 32'h55;
    check("same_rd", bus.out_rd, 5);
    check("same_imm", bus.out_imm, 9);
    issue(32'h0002_8333, 32'h118);        // add x6,x5,x0
    settle();
    check("same_sb_set", bus.in_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'h99;
    settle();
`ifdef DECODE_BYPASS_EN
    check("x6_wb_ready", bus.in_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    regs[5] = 32'h99;
`else
    check("x6_wb_ready", bus.in_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    regs[5] = 32'h99;
    settle();
    check("x6_post_wb_ready", bus.in_ready, 1);
    tick();
`endif
    check("x6_rd", bus.out_rd, 6);
    check("x6_op1", bus.out_op1, 32'h99);

    // Decode corner cases, back to back.
    issue(32'h0000_0013, 32'h11C);        // nop
    tick();
    check("nop_rd", bus.out_rd, 0);
    check("nop_imm", bus.out_imm, 0);
    check("nop_illegal", bus.out_illegal, 0);
    issue(32'h0000_037F, 32'h120);        // opcode 0x7F, rd field 6
    tick();
    check("ill_flag", bus.out_illegal, 1);
    check("ill_rd", bus.out_rd, 0);
    check("ill_opcode", bus.out_opcode, 7'h7F);
    issue(32'hFE00_0EE3, 32'h124);        // beq x0,x0,-4
    tick();
    check("br_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("br_rd", bus.out_rd, 0);
    issue(32'h0020_2423, 32'h128);        // sw x2,8(x0)
    tick();
    check("sw_imm", bus.out_imm, 8);
    check("sw_op2", bus.out_op2, 7);
    check("sw_funct3", bus.out_funct3, 2);
    check("sw_rd", bus.out_rd, 0);
    issue(32'h1234_53B7, 32'h12C);        // lui x7,0x12345
    tick();
    check("lui_imm", bus.out_imm, 32'h1234_5000);
    check("lui_rd", bus.out_rd, 7);
    check("lui_pc", bus.out_pc, 32'h12C);

    // Reset mid-stream clears the x3 busy bit left by add x3.
    issue(32'h0001_8433, 32'h130);        // add x8,x3,x0
    settle();
    check("x3_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    settle();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    check("mid_rst_rd", bus.out_rd, 0);
    tick();
    rst_n = 1'b1;
    settle();
    check("post_rst_ready", bus.in_ready, 1);
    tick();
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_rd", bus.out_rd, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
